// File: rtl/cache_set_controller_if.sv
// Request, comparator, refill and response signals of the cache set controller.
// The controller attaches through the slave modport; the CPU/comparator/memory side through master.
interface cache_set_controller_if #(
    parameter int TAG_W   = 36,
    parameter int INDEX_W = 6
);
    logic                     cpu_req_valid;
    logic                     cpu_req_ready;
    logic [TAG_W-1:0]         cpu_tag;
    logic [INDEX_W-1:0]       cpu_index;
    logic                     flush;
    logic [TAG_W-1:0]         tag_compare;
    logic [INDEX_W-1:0]       tag_index;
    logic [3:0]               vbit;
    logic                     hit;
    logic [3:0]               hit_way;
    logic                     mem_rd_req;
    logic [TAG_W+INDEX_W-1:0] mem_rd_addr;
    logic                     mem_rd_ack;
    logic                     fill_we;
    logic [3:0]               fill_way;
    logic [TAG_W-1:0]         fill_tag;
    logic                     resp_valid;
    logic                     resp_hit;
    logic [1:0]               resp_way;

    modport slave (
        input  cpu_req_valid, cpu_tag, cpu_index, flush, hit, hit_way, mem_rd_ack,
        output cpu_req_ready, tag_compare, tag_index, vbit, mem_rd_req, mem_rd_addr,
               fill_we, fill_way, fill_tag, resp_valid, resp_hit, resp_way
    );

    modport master (
        output cpu_req_valid, cpu_tag, cpu_index, flush, hit, hit_way, mem_rd_ack,
        input  cpu_req_ready, tag_compare, tag_index, vbit, mem_rd_req, mem_rd_addr,
               fill_we, fill_way, fill_tag, resp_valid, resp_hit, resp_way
    );
endinterface

// File: rtl/cache_set_controller.sv
// Request-side controller for a 4-way set-associative cache: lookup sequencing,
// miss refill handshake, per-set valid bits and tree pseudo-LRU replacement.
module cache_set_controller #(
    parameter int TAG_W   = 36,
    parameter int INDEX_W = 6
) (
    input logic                  clk,
    input logic                  rst,
    cache_set_controller_if.slave bus
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESP} state_t;

    state_t             state;
    state_t             state_nx;
    logic [3:0]         valid [SETS];
    logic [2:0]         plru  [SETS];   // {b2, b1, b0}
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [1:0]         victim_q;
    logic               resp_hit_q;
    logic [1:0]         resp_way_q;

    logic               accept;
    logic               hit_ok;
    logic [1:0]         hit_idx;
    logic [3:0]         cur_valid;
    logic [1:0]         miss_victim;

    function automatic logic [1:0] lowest_way(input logic [3:0] m);
        logic [1:0] w;
        w = 2'd0;
        if (m[0])      w = 2'd0;
        else if (m[1]) w = 2'd1;
        else if (m[2]) w = 2'd2;
        else if (m[3]) w = 2'd3;
        return w;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] p);
        return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    endfunction

    // Point the tree away from the accessed way; bits of the other pair are untouched.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] n;
        n = p;
        case (w)
            2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
            2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
            2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
            default: begin n[0] = 1'b0; n[2] = 1'b0; end
        endcase
        return n;
    endfunction

    assign bus.cpu_req_ready = (state == IDLE) && !rst && !bus.flush;
    assign accept            = bus.cpu_req_valid && bus.cpu_req_ready;
    assign hit_ok            = bus.hit && (bus.hit_way != 4'b0000);
    assign hit_idx           = lowest_way(bus.hit_way);
    assign cur_valid         = valid[index_q];
    assign miss_victim       = (&cur_valid) ? plru_victim(plru[index_q]) : lowest_way(~cur_valid);

    assign bus.tag_compare = tag_q;
    assign bus.tag_index   = index_q;
    assign bus.vbit        = cur_valid;
    assign bus.mem_rd_addr = {tag_q, index_q};
    assign bus.fill_tag    = tag_q;
    assign bus.resp_hit    = resp_hit_q;
    assign bus.resp_way    = resp_way_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.mem_rd_req = 1'b0;
        bus.fill_we    = 1'b0;
        bus.fill_way   = 4'b0000;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE:     if (accept) state_nx = LOOKUP;
            LOOKUP:   state_nx = hit_ok ? RESP : MISS_REQ;
            MISS_REQ: begin
                bus.mem_rd_req = 1'b1;
                if (bus.mem_rd_ack) state_nx = FILL;
            end
            FILL: begin
                bus.fill_we  = 1'b1;
                bus.fill_way = 4'b0001 << victim_q;
                state_nx     = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_nx       = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                valid[i] <= 4'b0000;
                plru[i]  <= 3'b000;
            end
            tag_q      <= '0;
            index_q    <= '0;
            victim_q   <= 2'd0;
            resp_hit_q <= 1'b0;
            resp_way_q <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        for (int i = 0; i < SETS; i++) begin
                            valid[i] <= 4'b0000;
                            plru[i]  <= 3'b000;
                        end
                    end else if (accept) begin
                        tag_q   <= bus.cpu_tag;
                        index_q <= bus.cpu_index;
                    end
                end
                LOOKUP: begin
                    if (hit_ok) begin
                        plru[index_q] <= plru_touch(plru[index_q], hit_idx);
                        resp_hit_q    <= 1'b1;
                        resp_way_q    <= hit_idx;
                    end else begin
                        victim_q <= miss_victim;
                    end
                end
                FILL: begin
                    valid[index_q] <= cur_valid | (4'b0001 << victim_q);
                    plru[index_q]  <= plru_touch(plru[index_q], victim_q);
                    resp_hit_q     <= 1'b0;
                    resp_way_q     <= victim_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_set_controller.sv
// Directed bench: stimulus pushes expected responses/fills into queues, a forked
// monitor pops and compares them whenever the controller presents resp_valid or fill_we.
module tb_cache_set_controller;
    typedef struct {
        bit       hit;
        bit [1:0] way;
        int       lat;
        int       acc;
    } resp_t;

    typedef struct {
        bit [3:0]  way;
        bit [35:0] tag;
    } fill_t;

    logic  clk;
    logic  rst;
    int    cyc;
    int    checks;
    int    errors;
    resp_t rq[$];
    fill_t fq[$];

    cache_set_controller_if #(.TAG_W(36), .INDEX_W(6)) b();

    cache_set_controller #(.TAG_W(36), .INDEX_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Latency is counted in rising edges from the acceptance edge to the edge
    // that samples resp_valid; the monitor sees resp_valid one negedge earlier.
    task automatic monitor();
        resp_t r;
        fill_t f;
        forever begin
            @(negedge clk);
            if (b.resp_valid) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_hit", b.resp_hit, r.hit);
                    chk("resp_way", b.resp_way, r.way);
                    chk("resp_latency", cyc + 1 - r.acc, r.lat);
                end
            end
            if (b.fill_we) begin
                if (fq.size() == 0) begin
                    chk("fill_unexpected", 1, 0);
                end else begin
                    f = fq.pop_front();
                    chk("fill_way", b.fill_way, f.way);
                    chk("fill_tag", b.fill_tag, f.tag);
                end
            end
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!b.cpu_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 1, 0);
    endtask

    task automatic do_req(input logic [35:0] t, input logic [5:0] idx, input bit h,
                          input logic [3:0] hw, input int ack_dly, input bit exp_hit,
                          input logic [1:0] exp_way, input logic [3:0] exp_vbit);
        resp_t r;
        fill_t f;
        int    n;
        @(negedge clk);
        b.cpu_req_valid = 1'b1;
        b.cpu_tag       = t;
        b.cpu_index     = idx;
        wait_ready();
        @(negedge clk);
        b.cpu_req_valid = 1'b0;
        chk("vbit_lookup", b.vbit, exp_vbit);
        chk("tag_compare", b.tag_compare, t);
        b.hit     = h;
        b.hit_way = hw;
        r.hit = exp_hit;
        r.way = exp_way;
        r.lat = exp_hit ? 2 : 4 + ack_dly;
        r.acc = cyc;
        rq.push_back(r);
        if (!exp_hit) begin
            f.way = 4'b0001 << exp_way;
            f.tag = t;
            fq.push_back(f);
        end
        @(negedge clk);
        b.hit     = 1'b0;
        b.hit_way = 4'b0000;
        if (exp_hit) begin
            chk("no_mem_req_on_hit", b.mem_rd_req, 0);
        end else begin
            repeat (ack_dly) @(negedge clk);
            chk("mem_rd_req", b.mem_rd_req, 1);
            chk("mem_rd_addr", b.mem_rd_addr, {t, idx});
            b.mem_rd_ack = 1'b1;
            @(negedge clk);
            b.mem_rd_ack = 1'b0;
            chk("mem_req_drops", b.mem_rd_req, 0);
        end
        n = 0;
        while (rq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("resp_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst             = 1'b1;
        b.cpu_req_valid = 1'b0;
        b.cpu_tag       = '0;
        b.cpu_index     = '0;
        b.flush         = 1'b0;
        b.hit           = 1'b0;
        b.hit_way       = 4'b0000;
        b.mem_rd_ack    = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        chk("ready_in_reset", b.cpu_req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", b.cpu_req_ready, 1);
        chk("rst_tag_compare", b.tag_compare, 0);
        chk("rst_tag_index", b.tag_index, 0);
        chk("rst_vbit", b.vbit, 0);
        chk("rst_outputs", {b.mem_rd_req, b.fill_we, b.resp_valid}, 0);

        // Test 1: cold miss, ack three cycles late; then test 2: hit on the filled way.
        do_req(36'hAB, 6'd5, 0, 4'b0000, 3, 0, 2'd0, 4'b0000);
        do_req(36'hAB, 6'd5, 1, 4'b0001, 0, 1, 2'd0, 4'b0001);

        // Test 3: fill set 3, hit way 0, fifth miss evicts way 2.
        do_req(36'h100, 6'd3, 0, 4'b0000, 0, 0, 2'd0, 4'b0000);
        do_req(36'h101, 6'd3, 0, 4'b0000, 0, 0, 2'd1, 4'b0001);
        do_req(36'h102, 6'd3, 0, 4'b0000, 1, 0, 2'd2, 4'b0011);
        do_req(36'h103, 6'd3, 0, 4'b0000, 0, 0, 2'd3, 4'b0111);
        do_req(36'h100, 6'd3, 1, 4'b0001, 0, 1, 2'd0, 4'b1111);
        do_req(36'h104, 6'd3, 0, 4'b0000, 0, 0, 2'd2, 4'b1111);

        // Test 4: one-cycle flush with a competing request that must not be taken.
        @(negedge clk);
        b.flush         = 1'b1;
        b.cpu_req_valid = 1'b1;
        b.cpu_tag       = 36'h999;
        b.cpu_index     = 6'd3;
        #1;
        chk("ready_during_flush", b.cpu_req_ready, 0);
        @(negedge clk);
        b.flush         = 1'b0;
        b.cpu_req_valid = 1'b0;
        do_req(36'hAB, 6'd5, 1, 4'b0001, 0, 1, 2'd0, 4'b0000);
        do_req(36'h200, 6'd3, 0, 4'b0000, 0, 0, 2'd0, 4'b0000);
        // hit without any matching way is a miss
        do_req(36'h300, 6'd3, 1, 4'b0000, 1, 0, 2'd1, 4'b0001);

        // Test 5: reset while waiting for the refill ack.
        @(negedge clk);
        b.cpu_req_valid = 1'b1;
        b.cpu_tag       = 36'h55;
        b.cpu_index     = 6'd9;
        wait_ready();
        @(negedge clk);
        b.cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("t5_mem_rd_req", b.mem_rd_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_req_drop", b.mem_rd_req, 0);
        chk("t5_no_fill_resp", {b.fill_we, b.resp_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_ready", b.cpu_req_ready, 1);
        chk("t5_vbit", b.vbit, 0);
        do_req(36'h400, 6'd3, 0, 4'b0000, 0, 0, 2'd0, 4'b0000);

        // Test 6: full set 7, multi-hit resolves to way 1, next miss evicts way 2.
        do_req(36'h700, 6'd7, 0, 4'b0000, 0, 0, 2'd0, 4'b0000);
        do_req(36'h701, 6'd7, 0, 4'b0000, 0, 0, 2'd1, 4'b0001);
        do_req(36'h702, 6'd7, 0, 4'b0000, 0, 0, 2'd2, 4'b0011);
        do_req(36'h703, 6'd7, 0, 4'b0000, 0, 0, 2'd3, 4'b0111);
        do_req(36'h701, 6'd7, 1, 4'b0110, 0, 1, 2'd1, 4'b1111);
        do_req(36'h704, 6'd7, 0, 4'b0000, 2, 0, 2'd2, 4'b1111);

        repeat (3) @(negedge clk);
        chk("resp_queue_drained", rq.size(), 0);
        chk("fill_queue_drained", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
